wb32_sram_initiator: RTL and testbench
======================================

// Module: wb32_sram_initiator
// PURPOSE
//  Wishbone initiator that turns 32-bit requests into one or two 16-bit cycles on the SRAM
//  controller's Wishbone port (sel/we/adr[19:1]/dat/stb/ack).
//  Sits between the 32-bit system bus and the 16-bit SRAM bridge.
//  Little-endian: low halfword at {adr,0}, high halfword at {adr,1}.
// PARAMETERS
//  AW          19  downstream halfword address width (m_adr_o = AW bits, upstream word adr = AW-1 bits)
//  SKIP_EMPTY  1   1: writes skip halves whose sel pair is 00; 0: always run both halves
// PORTS
//  clk_i      in   1      single clock, shared with SRAM controller
//  rst_ni     in   1      asynchronous active-low reset
//  s_cyc_i    in   1      upstream cycle
//  s_stb_i    in   1      upstream strobe
//  s_we_i     in   1      upstream write enable
//  s_adr_i    in   AW-1   upstream 32-bit word address
//  s_sel_i    in   4      upstream byte selects
//  s_dat_i    in   32     upstream write data
//  s_dat_o    out  32     upstream read data, valid while s_ack_o=1
//  s_ack_o    out  1      upstream acknowledge, one-cycle pulse
//  m_cyc_o    out  1      downstream cycle
//  m_stb_o    out  1      downstream strobe
//  m_we_o     out  1      downstream write enable
//  m_adr_o    out  AW     downstream halfword address
//  m_sel_o    out  2      downstream byte selects
//  m_dat_o    out  16     downstream write data
//  m_dat_i    in   16     downstream read data
//  m_ack_i    in   1      downstream acknowledge; may be combinational from m_stb_o
// BEHAVIOUR
//  Reset: state=IDLE, s_ack_o/m_cyc_o/m_stb_o/m_we_o=0, m_adr_o/m_sel_o/m_dat_o/s_dat_o=0, all latches cleared.
//  FSM IDLE -> LO -> HI -> ACK -> IDLE. All outputs are registered or decoded from state + latches only.
//  IDLE: on s_cyc_i&s_stb_i latch adr/we/sel/dat.
//   Next state: read -> LO; write sel[1:0]!=0 -> LO; write sel[1:0]==0, sel[3:2]!=0 -> HI;
//   write sel==0 -> ACK. With SKIP_EMPTY=0 every request goes to LO.
//  LO: m_cyc=m_stb=1, m_adr={adr_q,1'b0}, m_sel=we?sel_q[1:0]:2'b11, m_dat=dat_q[15:0].
//   m_ack_i=1: read captures m_dat_i into rd[15:0]; go HI, or ACK if write and skip-high (sel_q[3:2]==0, SKIP_EMPTY=1).
//   m_ack_i=0: hold state and all outputs (wait states unbounded).
//  HI: as LO with m_adr={adr_q,1'b1}, sel_q[3:2], dat_q[31:16]; m_ack_i -> rd[31:16], go ACK.
//  ACK: m_cyc=m_stb=0, s_ack_o=1 exactly one cycle, s_dat_o=rd (unselected read bytes still valid);
//   next IDLE. A request held on the following cycle starts a new transaction (no reuse of latches).
//  Latency with zero-wait-state slave: full 32-bit op = request cycle + 2 + ack -> s_ack_o 3 cycles
//   after request first sampled; single-half write -> 2 cycles; sel==0 write -> 1 cycle.
//  Abort: s_cyc_i=0 while in LO/HI -> next state IDLE, m_cyc/m_stb drop next edge, no s_ack_o.
//   A half acked in the same cycle as the abort is committed (writes cannot be undone).
//  s_stb_i drop without s_cyc_i drop in LO/HI: ignored, transaction completes.
//  Address: adr_q+{0,1} never carries; HI half of top word = highest halfword, no wrap logic.
//  rst_ni low mid-transaction: outputs to reset values immediately, m_stb_o drops asynchronously.
// TESTING
//  T1: write adr=0x1234 sel=1111 dat=0xDEADBEEF, 0-wait slave
//      -> m cycles {0x02468,sel 11,0xBEEF},{0x02469,sel 11,0xDEAD}; s_ack_o on 3rd cycle after request.
//  T2: read back adr=0x1234, model returns 0xBEEF/0xDEAD
//      -> s_dat_o=0xDEADBEEF with s_ack_o, m_we_o=0, m_sel_o=11 both halves.
//  T3: write sel=0100 dat=0x00AA0000 -> only HI cycle, m_sel_o=01, m_dat_o=0x00AA; sel=0000 -> no m_stb_o, ack next cycle.
//  T4: slave inserts 3 wait states per half -> outputs stable while waiting, s_ack_o 9 cycles after request, one pulse.
//  T5: drop s_cyc_i during LO with m_ack_i=0 -> m_stb_o low next cycle, no s_ack_o; next request runs normally.
//  T6: assert rst_ni=0 during HI -> m_stb_o/m_cyc_o/s_ack_o 0 immediately; after release FSM idle, T1 passes again.

Source files
------------

// File: rtl/wb32_sram_initiator.sv
// -----------------------------------------------------------------------------
// wb32_sram_initiator
//
// Purpose:
//   Bridges a 32-bit Wishbone request onto the 16-bit Wishbone port of the
//   SRAM controller. Each 32-bit access becomes up to two halfword cycles:
//   the low halfword at {adr,0} first, then the high halfword at {adr,1}
//   (little-endian). With SKIP_EMPTY set, a write skips any half whose byte
//   selects are both clear. A write with no byte selects completes without
//   touching the SRAM.
//
// Parameters:
//   AW          downstream halfword address width (upstream word address is AW-1)
//   SKIP_EMPTY  1: writes skip halves with sel pair 00; 0: always run both halves
//
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   s_cyc_i, s_stb_i       upstream cycle / strobe
//   s_we_i                 upstream write enable
//   s_adr_i  [AW-2:0]      upstream word address
//   s_sel_i  [3:0]         upstream byte selects
//   s_dat_i  [31:0]        upstream write data
//   s_dat_o  [31:0]        upstream read data, valid while s_ack_o is high
//   s_ack_o                upstream acknowledge (single-cycle pulse)
//   m_cyc_o, m_stb_o       downstream cycle / strobe
//   m_we_o                 downstream write enable
//   m_adr_o  [AW-1:0]      downstream halfword address
//   m_sel_o  [1:0]         downstream byte selects
//   m_dat_o  [15:0]        downstream write data
//   m_dat_i  [15:0]        downstream read data
//   m_ack_i                downstream acknowledge (may be combinational from m_stb_o)
// -----------------------------------------------------------------------------
module wb32_sram_initiator #(
  parameter int AW         = 19,
  parameter bit SKIP_EMPTY = 1'b1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          s_cyc_i,
  input  logic          s_stb_i,
  input  logic          s_we_i,
  input  logic [AW-2:0] s_adr_i,
  input  logic [3:0]    s_sel_i,
  input  logic [31:0]   s_dat_i,
  output logic [31:0]   s_dat_o,
  output logic          s_ack_o,
  output logic          m_cyc_o,
  output logic          m_stb_o,
  output logic          m_we_o,
  output logic [AW-1:0] m_adr_o,
  output logic [1:0]    m_sel_o,
  output logic [15:0]   m_dat_o,
  input  logic [15:0]   m_dat_i,
  input  logic          m_ack_i
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    ACK  = 2'd3
  } state_t;

  state_t        state;
  state_t        state_next;

  // Request latches, captured once per transaction in IDLE.
  logic [AW-2:0] adr_q;
  logic          we_q;
  logic [3:0]    sel_q;
  logic [31:0]   dat_q;
  // Read data assembled from the two halfword beats.
  logic [31:0]   rd_q;

  logic          req;
  logic          skip_hi;

  assign req     = s_cyc_i & s_stb_i;
  // High half of a latched write can be skipped once the low half is done.
  assign skip_hi = SKIP_EMPTY && we_q && (sel_q[3:2] == 2'b00);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic. m_ack_i may depend combinationally on m_stb_o; that is
  // safe because m_stb_o is decoded from state only, never from m_ack_i.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (req) begin
          if (!SKIP_EMPTY || !s_we_i || (s_sel_i[1:0] != 2'b00)) begin
            state_next = LO;
          end else if (s_sel_i[3:2] != 2'b00) begin
            state_next = HI;
          end else begin
            state_next = ACK;
          end
        end
      end
      LO: begin
        // Abort wins over completion; a half acked in the same cycle has
        // already been committed by the slave.
        if (!s_cyc_i) begin
          state_next = IDLE;
        end else if (m_ack_i) begin
          state_next = skip_hi ? ACK : HI;
        end
      end
      HI: begin
        if (!s_cyc_i) begin
          state_next = IDLE;
        end else if (m_ack_i) begin
          state_next = ACK;
        end
      end
      ACK: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Request latches and read-data assembly
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      adr_q <= '0;
      we_q  <= 1'b0;
      sel_q <= 4'h0;
      dat_q <= 32'h0;
      rd_q  <= 32'h0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req) begin
            adr_q <= s_adr_i;
            we_q  <= s_we_i;
            sel_q <= s_sel_i;
            dat_q <= s_dat_i;
            // Fresh transaction: nothing from the previous read leaks out.
            rd_q  <= 32'h0;
          end
        end
        LO: begin
          if (m_ack_i && !we_q) begin
            rd_q[15:0] <= m_dat_i;
          end
        end
        HI: begin
          if (m_ack_i && !we_q) begin
            rd_q[31:16] <= m_dat_i;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs, decoded from state and latches only. Because state resets
  // asynchronously, the bus strobes drop the moment rst_ni goes low.
  // Reads always fetch both bytes of each half so the full word is valid.
  // ---------------------------------------------------------------------------
  always_comb begin
    s_ack_o = 1'b0;
    s_dat_o = 32'h0;
    m_cyc_o = 1'b0;
    m_stb_o = 1'b0;
    m_we_o  = 1'b0;
    m_adr_o = '0;
    m_sel_o = 2'b00;
    m_dat_o = 16'h0;
    unique case (state)
      LO: begin
        m_cyc_o = 1'b1;
        m_stb_o = 1'b1;
        m_we_o  = we_q;
        m_adr_o = {adr_q, 1'b0};
        m_sel_o = we_q ? sel_q[1:0] : 2'b11;
        m_dat_o = dat_q[15:0];
      end
      HI: begin
        m_cyc_o = 1'b1;
        m_stb_o = 1'b1;
        m_we_o  = we_q;
        m_adr_o = {adr_q, 1'b1};
        m_sel_o = we_q ? sel_q[3:2] : 2'b11;
        m_dat_o = dat_q[31:16];
      end
      ACK: begin
        s_ack_o = 1'b1;
        s_dat_o = rd_q;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_wb32_sram_initiator.sv
// -----------------------------------------------------------------------------
// tb_wb32_sram_initiator
//
// Randomized bench for wb32_sram_initiator. A halfword SRAM slave with a
// configurable number of wait states sits on the downstream port. Expected
// results come from a word-level memory model: byte-masked writes, full-word
// reads, the list of halfword beats each request should produce, and the
// acknowledge latency (beats * (waits + 1) + 1 clock edges).
// -----------------------------------------------------------------------------
module tb_wb32_sram_initiator;
  localparam int AW = 19;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          s_cyc_i = 1'b0;
  logic          s_stb_i = 1'b0;
  logic          s_we_i = 1'b0;
  logic [AW-2:0] s_adr_i = '0;
  logic [3:0]    s_sel_i = 4'h0;
  logic [31:0]   s_dat_i = 32'h0;
  logic [31:0]   s_dat_o;
  logic          s_ack_o;
  logic          m_cyc_o;
  logic          m_stb_o;
  logic          m_we_o;
  logic [AW-1:0] m_adr_o;
  logic [1:0]    m_sel_o;
  logic [15:0]   m_dat_o;
  logic [15:0]   m_dat_i;
  logic          m_ack_i;

  wb32_sram_initiator #(.AW(AW), .SKIP_EMPTY(1'b1)) dut (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .s_cyc_i (s_cyc_i),
    .s_stb_i (s_stb_i),
    .s_we_i  (s_we_i),
    .s_adr_i (s_adr_i),
    .s_sel_i (s_sel_i),
    .s_dat_i (s_dat_i),
    .s_dat_o (s_dat_o),
    .s_ack_o (s_ack_o),
    .m_cyc_o (m_cyc_o),
    .m_stb_o (m_stb_o),
    .m_we_o  (m_we_o),
    .m_adr_o (m_adr_o),
    .m_sel_o (m_sel_o),
    .m_dat_o (m_dat_o),
    .m_dat_i (m_dat_i),
    .m_ack_i (m_ack_i)
  );

  always #5 clk_i = ~clk_i;

  int checks_total  = 0;
  int checks_passed = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks_total++;
    if (got === exp) checks_passed++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // ---------------------------------------------------------------------------
  // Halfword SRAM slave with wait states
  // ---------------------------------------------------------------------------
  logic [15:0] ram [logic [AW-1:0]];
  int wait_cfg = 0;
  int wcnt = 0;

  function automatic logic [15:0] ram_rd(input logic [AW-1:0] a);
    if (ram.exists(a)) return ram[a];
    return 16'h0;
  endfunction

  assign m_ack_i = m_stb_o && (wcnt == wait_cfg);
  assign m_dat_i = ram_rd(m_adr_o);

  always @(posedge clk_i) begin
    if (!m_stb_o || m_ack_i) wcnt <= 0;
    else wcnt <= wcnt + 1;
  end

  typedef struct packed {
    logic [AW-1:0] adr;
    logic          we;
    logic [1:0]    sel;
    logic [15:0]   dat;
  } beat_t;

  beat_t beats[$];

  // Beat monitor: records accepted beats, performs slave writes and checks
  // that the request is held steady across wait states.
  initial begin
    beat_t cur;
    beat_t prev;
    bit    prev_wait;
    logic [15:0] w;
    prev_wait = 1'b0;
    prev = '0;
    forever begin
      @(negedge clk_i);
      if (m_stb_o) begin
        cur = '{adr: m_adr_o, we: m_we_o, sel: m_sel_o, dat: m_dat_o};
        if (prev_wait) check("wait_stable", cur, prev);
        if (m_ack_i) begin
          beats.push_back(cur);
          if (m_we_o) begin
            w = ram_rd(m_adr_o);
            if (m_sel_o[0]) w[7:0]  = m_dat_o[7:0];
            if (m_sel_o[1]) w[15:8] = m_dat_o[15:8];
            ram[m_adr_o] = w;
          end
        end
        prev_wait = !m_ack_i;
        prev = cur;
      end else begin
        prev_wait = 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Word-level reference model
  // ---------------------------------------------------------------------------
  logic [31:0] ref_mem [logic [AW-2:0]];

  function automatic logic [31:0] ref_rd(input logic [AW-2:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return 32'h0;
  endfunction

  task automatic ref_wr(input logic [AW-2:0] a, input logic [3:0] sel, input logic [31:0] d);
    logic [31:0] w;
    w = ref_rd(a);
    for (int b = 0; b < 4; b++) if (sel[b]) w[8*b +: 8] = d[8*b +: 8];
    ref_mem[a] = w;
  endtask

  // ---------------------------------------------------------------------------
  // One full transaction with latency, data, beat-sequence and pulse checks
  // ---------------------------------------------------------------------------
  task automatic run_txn(input string name, input logic we, input logic [AW-2:0] adr,
                         input logic [3:0] sel, input logic [31:0] dat, input int w);
    beat_t exp_q[$];
    int    lat;
    bit    got_ack;
    logic [31:0] rdat;
    int    n;
    for (int h = 0; h < 2; h++) begin
      logic [1:0] pair;
      pair = sel[2*h +: 2];
      if (!we || pair != 2'b00)
        exp_q.push_back('{adr: {adr, h[0]}, we: we, sel: (we ? pair : 2'b11), dat: dat[16*h +: 16]});
    end
    wait_cfg = w;
    beats.delete();
    @(negedge clk_i);
    s_cyc_i = 1'b1; s_stb_i = 1'b1; s_we_i = we;
    s_adr_i = adr;  s_sel_i = sel;  s_dat_i = dat;
    lat = 0;
    got_ack = 1'b0;
    while (!got_ack && lat < 200) begin
      @(posedge clk_i);
      lat++;
      @(negedge clk_i);
      if (s_ack_o) got_ack = 1'b1;
    end
    rdat = s_dat_o;
    s_cyc_i = 1'b0; s_stb_i = 1'b0;
    check({name, ".ack_seen"}, got_ack, 1'b1);
    check({name, ".latency"}, lat, exp_q.size() * (w + 1) + 1);
    if (!we) check({name, ".rdata"}, rdat, ref_rd(adr));
    else ref_wr(adr, sel, dat);
    check({name, ".nbeats"}, beats.size(), exp_q.size());
    n = (beats.size() < exp_q.size()) ? beats.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check({name, ".beat_adr"}, beats[i].adr, exp_q[i].adr);
      check({name, ".beat_we"},  beats[i].we,  exp_q[i].we);
      check({name, ".beat_sel"}, beats[i].sel, exp_q[i].sel);
      if (we) check({name, ".beat_dat"}, beats[i].dat, exp_q[i].dat);
    end
    @(negedge clk_i);
    check({name, ".ack_one_pulse"}, s_ack_o, 1'b0);
    check({name, ".idle_stb"}, m_stb_o, 1'b0);
    $display("txn %s we=%0d adr=%h sel=%b dat=%h waits=%0d lat=%0d rdat=%h beats=%0d",
             name, we, adr, sel, dat, w, lat, rdat, beats.size());
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int n;
    logic [AW-2:0] top_adr;
    top_adr = '1;

    // Reset state
    #2;
    check("rst.s_ack", s_ack_o, 1'b0);
    check("rst.m_cyc", m_cyc_o, 1'b0);
    check("rst.m_stb", m_stb_o, 1'b0);
    check("rst.m_we",  m_we_o,  1'b0);
    check("rst.m_adr", m_adr_o, 0);
    check("rst.m_sel", m_sel_o, 2'b00);
    check("rst.m_dat", m_dat_o, 16'h0);
    check("rst.s_dat", s_dat_o, 32'h0);
    repeat (3) @(negedge clk_i);
    rst_ni = 1'b1;

    // T1/T2: full write then read back, zero waits
    run_txn("t1_wr", 1'b1, 18'h01234, 4'b1111, 32'hDEADBEEF, 0);
    run_txn("t2_rd", 1'b0, 18'h01234, 4'b1111, 32'h0, 0);
    // T3: high-half-only write, then empty write
    run_txn("t3_hi", 1'b1, 18'h01234, 4'b0100, 32'h00AA0000, 0);
    run_txn("t3_none", 1'b1, 18'h01234, 4'b0000, 32'h12345678, 0);
    run_txn("t3_rd", 1'b0, 18'h01234, 4'b0000, 32'h0, 0);
    run_txn("lo_only", 1'b1, 18'h00010, 4'b0010, 32'h5566_7788, 1);
    // T4: three wait states per half
    run_txn("t4_wr", 1'b1, 18'h00020, 4'b1111, 32'h0BADF00D, 3);
    run_txn("t4_rd", 1'b0, 18'h00020, 4'b1111, 32'h0, 3);
    // Top word: highest halfword address, no wrap
    run_txn("top_wr", 1'b1, top_adr, 4'b1111, 32'hA5A55A5A, 0);
    run_txn("top_rd", 1'b0, top_adr, 4'b0001, 32'h0, 0);

    // T5: abort during LO while the slave is still waiting
    wait_cfg = 5;
    beats.delete();
    @(negedge clk_i);
    s_cyc_i = 1'b1; s_stb_i = 1'b1; s_we_i = 1'b1;
    s_adr_i = 18'h00030; s_sel_i = 4'b1111; s_dat_i = 32'h11112222;
    n = 0;
    do begin @(negedge clk_i); n++; end while (!m_stb_o && n < 20);
    check("t5.stb_up", m_stb_o, 1'b1);
    check("t5.lo_adr", m_adr_o, {18'h00030, 1'b0});
    s_cyc_i = 1'b0; s_stb_i = 1'b0;
    @(negedge clk_i);
    check("t5.stb_drop", m_stb_o, 1'b0);
    check("t5.cyc_drop", m_cyc_o, 1'b0);
    n = 0;
    repeat (4) begin
      if (s_ack_o) n++;
      @(negedge clk_i);
    end
    check("t5.no_ack", n, 0);
    check("t5.no_beats", beats.size(), 0);
    $display("txn t5_abort adr=00030 beats=%0d", beats.size());
    run_txn("t5_after", 1'b0, 18'h00030, 4'b1111, 32'h0, 0);

    // T6: reset asserted while the high half is waiting
    wait_cfg = 3;
    beats.delete();
    @(negedge clk_i);
    s_cyc_i = 1'b1; s_stb_i = 1'b1; s_we_i = 1'b1;
    s_adr_i = 18'h01234; s_sel_i = 4'b1111; s_dat_i = 32'hCAFEF00D;
    n = 0;
    do begin @(negedge clk_i); n++; end while (!(m_stb_o && m_adr_o[0]) && n < 40);
    check("t6.in_hi", m_stb_o && m_adr_o[0], 1'b1);
    #1 rst_ni = 1'b0;
    #1;
    check("t6.stb", m_stb_o, 1'b0);
    check("t6.cyc", m_cyc_o, 1'b0);
    check("t6.ack", s_ack_o, 1'b0);
    check("t6.adr", m_adr_o, 0);
    check("t6.beats", beats.size(), 1);
    ref_wr(18'h01234, 4'b0011, 32'hCAFEF00D);
    $display("txn t6_reset adr=01234 beats=%0d", beats.size());
    s_cyc_i = 1'b0; s_stb_i = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    run_txn("t6_rd", 1'b0, 18'h01234, 4'b1111, 32'h0, 0);
    run_txn("t6_t1", 1'b1, 18'h01234, 4'b1111, 32'hDEADBEEF, 0);
    run_txn("t6_t2", 1'b0, 18'h01234, 4'b1111, 32'h0, 0);

    // Randomized traffic over a small address set so reads hit earlier writes
    for (int i = 0; i < 40; i++) begin
      logic          we;
      logic [AW-2:0] adr;
      we  = 1'($urandom_range(0, 1));
      adr = ($urandom_range(0, 7) == 0) ? top_adr : 18'($urandom_range(0, 7));
      run_txn($sformatf("rnd%0d", i), we, adr, 4'($urandom_range(0, 15)), $urandom,
              $urandom_range(0, 2));
    end

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
